// File: rtl/icache_pkg.sv
// Shared types and geometry for the direct-mapped instruction cache.
package icache_pkg;

    localparam int NUM_BLOCKS  = 8;
    localparam int BLOCK_WORDS = 4;
    localparam int TAG_W       = 3;
    localparam int INDEX_W     = 3;
    localparam int OFFSET_W    = 2;
    localparam int WORD_W      = 32;
    localparam int BLOCK_W     = BLOCK_WORDS * WORD_W;
    localparam int MADDR_W     = TAG_W + INDEX_W;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_READ = 2'd1,
        ST_UPDATE   = 2'd2
    } state_t;

    typedef struct packed {
        logic               valid;
        logic [TAG_W-1:0]   tag;
        logic [BLOCK_W-1:0] data;
    } line_t;

    // Pick one 32-bit word out of a block; word k lives at bits [32k+31:32k].
    function automatic logic [WORD_W-1:0] select_word(
        input logic [BLOCK_W-1:0]  blk,
        input logic [OFFSET_W-1:0] off
    );
        logic [WORD_W-1:0] w;
        case (off)
            2'd0:    w = blk[31:0];
            2'd1:    w = blk[63:32];
            2'd2:    w = blk[95:64];
            default: w = blk[127:96];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/instr_cache_array.sv
// Line storage for the instruction cache: valid bits, tags and block data.
// Writes and the valid clear are synchronous; reads are combinational by index.
module instr_cache_array
    import icache_pkg::*;
(
    input  logic               clk,
    input  logic               clear,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [BLOCK_W-1:0] wr_data,
    input  logic [INDEX_W-1:0] rd_index,
    output line_t              rd_line
);

    logic [NUM_BLOCKS-1:0] valid;
    logic [TAG_W-1:0]      tag_mem  [NUM_BLOCKS];
    logic [BLOCK_W-1:0]    data_mem [NUM_BLOCKS];

    // Valid bits: cleared wholesale, set when a fill lands in a line.
    always_ff @(posedge clk) begin
        if (clear) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_index] <= 1'b1;
        end
    end

    // Tag and data payload; only meaningful once the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (!clear && wr_en) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_data;
        end
    end

    // Combinational line read for the hit compare and word select.
    always_comb begin
        rd_line.valid = valid[rd_index];
        rd_line.tag   = tag_mem[rd_index];
        rd_line.data  = data_mem[rd_index];
    end

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache between CPU fetch and instruction memory.
//
//  state       | meaning
//  ------------+-----------------------------------------------------------
//  ST_IDLE     | serve hits combinationally; a miss stalls and latches PC[9:4]
//  ST_MEM_READ | request the latched block; wait for memory to drop busywait
//  ST_UPDATE   | write the captured block, tag and valid into the latched line
module instr_cache
    import icache_pkg::*;
(
    input  logic               CLK,
    input  logic               RESET,
    input  logic [31:0]        PC,
    output logic [WORD_W-1:0]  INSTRUCTION,
    output logic               BUSYWAIT,
    output logic               MEM_READ,
    output logic [MADDR_W-1:0] MEM_ADDRESS,
    input  logic [BLOCK_W-1:0] MEM_READDATA,
    input  logic               MEM_BUSYWAIT
);

    state_t               state;
    state_t               next_state;
    logic [MADDR_W-1:0]   miss_addr;
    logic [BLOCK_W-1:0]   fill_data;
    logic [WORD_W-1:0]    last_instr;
    logic [INDEX_W-1:0]   pc_index;
    logic [TAG_W-1:0]     pc_tag;
    logic [OFFSET_W-1:0]  pc_offset;
    line_t                cur_line;
    logic                 hit;
    logic [WORD_W-1:0]    hit_word;
    logic                 busy;
    logic                 mem_rd;
    logic                 wr_en;
    logic                 unused_pc;

    assign pc_offset = PC[3:2];
    assign pc_index  = PC[6:4];
    assign pc_tag    = PC[9:7];
    assign unused_pc = ^{PC[31:10], PC[1:0]};

    instr_cache_array u_array (
        .clk      (CLK),
        .clear    (!RESET),
        .wr_en    (wr_en),
        .wr_index (miss_addr[INDEX_W-1:0]),
        .wr_tag   (miss_addr[MADDR_W-1:INDEX_W]),
        .wr_data  (fill_data),
        .rd_index (pc_index),
        .rd_line  (cur_line)
    );

    assign hit      = cur_line.valid && (cur_line.tag == pc_tag);
    assign hit_word = select_word(cur_line.data, pc_offset);
    assign wr_en    = RESET && (state == ST_UPDATE);

    // State register; reset abandons any fill in flight.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Miss address, fill buffer and the held instruction shown while stalled.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            miss_addr  <= '0;
            fill_data  <= '0;
            last_instr <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (hit) begin
                        last_instr <= hit_word;
                    end else begin
                        miss_addr <= PC[9:4];
                    end
                end
                ST_MEM_READ: begin
                    if (!MEM_BUSYWAIT) begin
                        fill_data <= MEM_READDATA;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state and control decode.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        mem_rd     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!hit) begin
                    busy       = 1'b1;
                    next_state = ST_MEM_READ;
                end
            end
            ST_MEM_READ: begin
                busy   = 1'b1;
                mem_rd = 1'b1;
                if (!MEM_BUSYWAIT) begin
                    next_state = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                busy       = 1'b1;
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Outputs sit at their reset values while RESET is held low; while stalled
    // the last delivered instruction is held rather than the raw array word.
    always_comb begin
        BUSYWAIT    = RESET && busy;
        MEM_READ    = RESET && mem_rd;
        MEM_ADDRESS = RESET ? miss_addr : '0;
        if (!RESET) begin
            INSTRUCTION = '0;
        end else if ((state == ST_IDLE) && hit) begin
            INSTRUCTION = hit_word;
        end else begin
            INSTRUCTION = last_instr;
        end
    end

endmodule

// File: tb/tb_instr_cache.sv
// Directed self-checking bench for instr_cache with a behavioural block memory.
module tb_instr_cache;

    logic         CLK;
    logic         RESET;
    logic [31:0]  PC;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic         MEM_READ;
    logic [5:0]   MEM_ADDRESS;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;

    int tests;
    int fails;
    int mem_wait;
    int mem_cnt;

    instr_cache dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .PC           (PC),
        .INSTRUCTION  (INSTRUCTION),
        .BUSYWAIT     (BUSYWAIT),
        .MEM_READ     (MEM_READ),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_READDATA (MEM_READDATA),
        .MEM_BUSYWAIT (MEM_BUSYWAIT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory contents: word k of block a is a*16 + k.
    function automatic logic [127:0] block_of(input logic [5:0] a);
        logic [127:0] b;
        for (int k = 0; k < 4; k++) begin
            b[32*k +: 32] = {22'd0, a, 4'(k)};
        end
        return b;
    endfunction

    // Memory responder: busy for mem_wait cycles of MEM_READ, then ready.
    always @(negedge CLK) begin
        if (MEM_READ === 1'b1) begin
            mem_cnt      = mem_cnt + 1;
            MEM_BUSYWAIT = (mem_cnt <= mem_wait);
            MEM_READDATA = block_of(MEM_ADDRESS);
        end else begin
            mem_cnt      = 0;
            MEM_BUSYWAIT = 1'b0;
        end
    end

    task automatic drive_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample_point();
        @(negedge CLK);
        #1;
    endtask

    // Run until BUSYWAIT drops, tracking fills, addresses and the held instruction.
    task automatic wait_fill(
        input  int          chg_cycle,
        input  logic [31:0] chg_pc,
        input  logic [31:0] held,
        output int          cycles,
        output int          fills,
        output logic [5:0]  first_addr,
        output logic [5:0]  last_addr,
        output bit          addr_stable,
        output bit          hold_ok,
        output bit          timed_out
    );
        logic       prev_rd;
        logic [5:0] cur;
        cycles      = 0;
        fills       = 0;
        first_addr  = '1;
        last_addr   = '1;
        addr_stable = 1'b1;
        hold_ok     = 1'b1;
        timed_out   = 1'b0;
        prev_rd     = 1'b0;
        cur         = '0;
        for (int n = 1; n <= 200; n++) begin
            drive_cycle();
            if (n == chg_cycle) PC = chg_pc;
            sample_point();
            cycles = n;
            if (MEM_READ === 1'b1) begin
                if (!prev_rd) begin
                    fills = fills + 1;
                    if (fills == 1) first_addr = MEM_ADDRESS;
                    cur = MEM_ADDRESS;
                end else if (MEM_ADDRESS !== cur) begin
                    addr_stable = 1'b0;
                end
                last_addr = MEM_ADDRESS;
            end
            prev_rd = MEM_READ;
            if (BUSYWAIT === 1'b0) break;
            if (INSTRUCTION !== held) hold_ok = 1'b0;
            if (n == 200) timed_out = 1'b1;
        end
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        PC    = 32'h0;
        drive_cycle();
        drive_cycle();
        sample_point();
        tests++;
        if ({BUSYWAIT, MEM_READ} !== 2'b00) begin
            fails++;
            $display("FAIL reset_ctrl: busywait/mem_read=%b required 00", {BUSYWAIT, MEM_READ});
        end
        tests++;
        if (MEM_ADDRESS !== 6'd0 || INSTRUCTION !== 32'd0) begin
            fails++;
            $display("FAIL reset_out: addr=%0d instr=%h required 0/0", MEM_ADDRESS, INSTRUCTION);
        end
        tests++;
        if (dut.u_array.valid !== 8'h00) begin
            fails++;
            $display("FAIL reset_valid: valid=%b required 00000000", dut.u_array.valid);
        end
    endtask

    task automatic test_cold_miss();
        int bad;
        mem_wait = 3;
        drive_cycle();
        RESET = 1'b1;
        PC    = 32'h0;
        sample_point();
        tests++;
        if (BUSYWAIT !== 1'b1 || MEM_READ !== 1'b0) begin
            fails++;
            $display("FAIL cold_miss_stall: busywait=%b mem_read=%b required 1/0", BUSYWAIT, MEM_READ);
        end
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            drive_cycle();
            sample_point();
            if (MEM_READ !== 1'b1 || MEM_ADDRESS !== 6'd0 || BUSYWAIT !== 1'b1) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL cold_miss_read: %0d bad MEM_READ cycles required 0", bad);
        end
        drive_cycle();
        sample_point();
        tests++;
        if (MEM_READ !== 1'b0 || BUSYWAIT !== 1'b1) begin
            fails++;
            $display("FAIL cold_miss_update: mem_read=%b busywait=%b required 0/1", MEM_READ, BUSYWAIT);
        end
        drive_cycle();
        sample_point();
        tests++;
        if (BUSYWAIT !== 1'b0 || INSTRUCTION !== 32'h0) begin
            fails++;
            $display("FAIL cold_miss_hit: busywait=%b instr=%h required 0/00000000", BUSYWAIT, INSTRUCTION);
        end
    endtask

    task automatic test_same_block_hits();
        logic [31:0] pcs [3];
        logic [31:0] exp [3];
        pcs = '{32'h4, 32'h8, 32'hC};
        exp = '{32'h1, 32'h2, 32'h3};
        for (int i = 0; i < 3; i++) begin
            drive_cycle();
            PC = pcs[i];
            sample_point();
            tests++;
            if (INSTRUCTION !== exp[i] || BUSYWAIT !== 1'b0 || MEM_READ !== 1'b0) begin
                fails++;
                $display("FAIL hit_pc_%h: instr=%h busy=%b mrd=%b required %h/0/0",
                         pcs[i], INSTRUCTION, BUSYWAIT, MEM_READ, exp[i]);
            end
        end
    endtask

    task automatic test_conflict();
        int cyc, nf;
        logic [5:0] fa, la;
        bit st, ho, to;
        mem_wait = 1;
        drive_cycle();
        PC = 32'h80;
        sample_point();
        tests++;
        if (BUSYWAIT !== 1'b1 || INSTRUCTION !== 32'h3) begin
            fails++;
            $display("FAIL conflict_miss: busy=%b instr=%h required 1/00000003", BUSYWAIT, INSTRUCTION);
        end
        wait_fill(0, 32'h0, 32'h3, cyc, nf, fa, la, st, ho, to);
        tests++;
        if (to || cyc != 4 || nf != 1 || fa !== 6'd8 || !st || !ho || INSTRUCTION !== 32'h80) begin
            fails++;
            $display("FAIL conflict_fill: cyc=%0d fills=%0d addr=%0d stable=%0d hold=%0d instr=%h required 4/1/8/1/1/00000080",
                     cyc, nf, fa, st, ho, INSTRUCTION);
        end
        mem_wait = 0;
        drive_cycle();
        PC = 32'h0;
        sample_point();
        tests++;
        if (BUSYWAIT !== 1'b1) begin
            fails++;
            $display("FAIL conflict_remiss: busy=%b required 1", BUSYWAIT);
        end
        wait_fill(0, 32'h0, 32'h80, cyc, nf, fa, la, st, ho, to);
        tests++;
        if (to || cyc != 3 || nf != 1 || fa !== 6'd0 || !ho || INSTRUCTION !== 32'h0) begin
            fails++;
            $display("FAIL conflict_refill: cyc=%0d fills=%0d addr=%0d hold=%0d instr=%h required 3/1/0/1/00000000",
                     cyc, nf, fa, ho, INSTRUCTION);
        end
    endtask

    task automatic test_reset_mid_fill();
        int cyc, nf;
        logic [5:0] fa, la;
        bit st, ho, to;
        mem_wait = 5;
        drive_cycle();
        PC = 32'h80;
        sample_point();
        drive_cycle();
        sample_point();
        tests++;
        if (MEM_READ !== 1'b1 || MEM_ADDRESS !== 6'd8) begin
            fails++;
            $display("FAIL midfill_read: mrd=%b addr=%0d required 1/8", MEM_READ, MEM_ADDRESS);
        end
        drive_cycle();
        RESET = 1'b0;
        sample_point();
        drive_cycle();
        RESET = 1'b1;
        sample_point();
        tests++;
        if (MEM_READ !== 1'b0 || BUSYWAIT !== 1'b1 || dut.u_array.valid !== 8'h00) begin
            fails++;
            $display("FAIL midfill_abort: mrd=%b busy=%b valid=%b required 0/1/00000000",
                     MEM_READ, BUSYWAIT, dut.u_array.valid);
        end
        mem_wait = 1;
        wait_fill(0, 32'h0, 32'h0, cyc, nf, fa, la, st, ho, to);
        tests++;
        if (to || cyc != 4 || nf != 1 || fa !== 6'd8 || !ho || INSTRUCTION !== 32'h80) begin
            fails++;
            $display("FAIL midfill_refetch: cyc=%0d fills=%0d addr=%0d hold=%0d instr=%h required 4/1/8/1/00000080",
                     cyc, nf, fa, ho, INSTRUCTION);
        end
    endtask

    task automatic test_ignored_bits();
        drive_cycle();
        PC = 32'hABCD_0486;
        sample_point();
        tests++;
        if (BUSYWAIT !== 1'b0 || INSTRUCTION !== 32'h81) begin
            fails++;
            $display("FAIL ignored_bits: busy=%b instr=%h required 0/00000081", BUSYWAIT, INSTRUCTION);
        end
    endtask

    task automatic test_pre_reset_pc();
        int cyc, nf;
        logic [5:0] fa, la;
        bit st, ho, to;
        mem_wait = 1;
        drive_cycle();
        PC = 32'hFFFF_FFFC;
        sample_point();
        wait_fill(0, 32'h0, 32'h81, cyc, nf, fa, la, st, ho, to);
        tests++;
        if (to || cyc != 4 || nf != 1 || fa !== 6'h3F || !ho || INSTRUCTION !== 32'h3F3) begin
            fails++;
            $display("FAIL pre_reset_pc: cyc=%0d fills=%0d addr=%0d hold=%0d instr=%h required 4/1/63/1/000003f3",
                     cyc, nf, fa, ho, INSTRUCTION);
        end
    endtask

    task automatic test_pc_change_during_fill();
        int cyc, nf;
        logic [5:0] fa, la;
        bit st, ho, to;
        mem_wait = 2;
        drive_cycle();
        PC = 32'h10;
        sample_point();
        wait_fill(2, 32'h24, 32'h3F3, cyc, nf, fa, la, st, ho, to);
        tests++;
        if (to || cyc != 10 || nf != 2 || fa !== 6'd1 || la !== 6'd2 || !st || !ho) begin
            fails++;
            $display("FAIL pc_change_fills: cyc=%0d fills=%0d first=%0d last=%0d stable=%0d hold=%0d required 10/2/1/2/1/1",
                     cyc, nf, fa, la, st, ho);
        end
        tests++;
        if (INSTRUCTION !== 32'h21) begin
            fails++;
            $display("FAIL pc_change_instr: instr=%h required 00000021", INSTRUCTION);
        end
        drive_cycle();
        PC = 32'h10;
        sample_point();
        tests++;
        if (BUSYWAIT !== 1'b0 || INSTRUCTION !== 32'h10) begin
            fails++;
            $display("FAIL pc_change_first_line: busy=%b instr=%h required 0/00000010", BUSYWAIT, INSTRUCTION);
        end
    endtask

    initial begin
        tests        = 0;
        fails        = 0;
        mem_wait     = 0;
        mem_cnt      = 0;
        MEM_BUSYWAIT = 1'b0;
        MEM_READDATA = '0;
        RESET        = 1'b0;
        PC           = 32'h0;
        test_reset();
        test_cold_miss();
        test_same_block_hits();
        test_conflict();
        test_reset_mid_fill();
        test_ignored_bits();
        test_pre_reset_pc();
        test_pc_change_during_fill();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
